simmem_delay_tracker: RTL



---
 rtl/simmem_delay_tracker.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/simmem_delay_tracker.sv
// Delay tracker for simulated-memory responses: per-slot countdown, AXI same-ID ordering, release tokens.
// Define SIMMEM_DELAY_TRACKER_OCCUPANCY_EN to add the registered occupancy_o slot count.
module simmem_delay_tracker #(
    parameter int unsigned NumSlots     = 16,
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned CounterWidth = 8,
    parameter int unsigned BaseDelay    = 4,
    parameter int unsigned BeatDelay    = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        addr_valid_i,
    output logic                        addr_ready_o,
    input  logic [IdWidth-1:0]          addr_id_i,
    input  logic [7:0]                  addr_len_i,
    output logic                        rel_valid_o,
    input  logic                        rel_ready_i,
    output logic [IdWidth-1:0]          rel_id_o,
    output logic [$clog2(NumSlots)-1:0] rel_slot_o
`ifdef SIMMEM_DELAY_TRACKER_OCCUPANCY_EN
    ,
    output logic [$clog2(NumSlots):0]   occupancy_o
`endif
);
    localparam int unsigned SlotW  = $clog2(NumSlots);
    localparam logic [15:0] CntMax = 16'((32'd1 << CounterWidth) - 32'd1);

    logic [NumSlots-1:0]     valid_q, valid_d;
    logic [IdWidth-1:0]      id_q    [NumSlots];
    logic [IdWidth-1:0]      id_d    [NumSlots];
    logic [CounterWidth-1:0] cnt_q   [NumSlots];
    logic [CounterWidth-1:0] cnt_d   [NumSlots];
    logic [NumSlots-1:0]     older_q [NumSlots];
    logic [NumSlots-1:0]     older_d [NumSlots];

    logic               rel_valid_q, rel_valid_d;
    logic [IdWidth-1:0] rel_id_q, rel_id_d;
    logic [SlotW-1:0]   rel_slot_q, rel_slot_d;

    logic [NumSlots-1:0]     eligible;
    logic                    alloc_found, alloc_en;
    logic [SlotW-1:0]        alloc_idx;
    logic                    pick_found, rel_load, release_en;
    logic [SlotW-1:0]        pick_idx;
    logic [15:0]             delay16;
    logic [CounterWidth-1:0] delay_sat;

    assign addr_ready_o = ~&valid_q;
    assign alloc_en     = addr_valid_i & addr_ready_o;
    assign rel_load     = ~rel_valid_q | rel_ready_i;
    assign release_en   = rel_load & pick_found;

    assign delay16   = 16'(BaseDelay) + (16'(addr_len_i) + 16'd1) * 16'(BeatDelay);
    assign delay_sat = (delay16 > CntMax) ? CounterWidth'(CntMax) : CounterWidth'(delay16);

    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int unsigned i = 0; i < NumSlots; i++) begin
            if (!valid_q[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = SlotW'(i);
            end
        end
    end

    // A slot is held back while any valid, older slot carries the same ID.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NumSlots; i++) begin
            eligible[i] = valid_q[i] && (cnt_q[i] == '0);
            for (int unsigned j = 0; j < NumSlots; j++) begin
                if (valid_q[j] && older_q[j][i] && (id_q[j] == id_q[i])) begin
                    eligible[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NumSlots; i++) begin
            if (eligible[i] && !pick_found) begin
                pick_found = 1'b1;
                pick_idx   = SlotW'(i);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        older_d = older_q;
        for (int unsigned i = 0; i < NumSlots; i++) begin
            cnt_d[i] = (valid_q[i] && (cnt_q[i] != '0)) ? cnt_q[i] - CounterWidth'(1) : cnt_q[i];
        end
        if (release_en) begin
            valid_d[pick_idx] = 1'b0;
        end
        // Row cleared and column rebuilt, so stale bits of freed slots never matter.
        if (alloc_en) begin
            valid_d[alloc_idx] = 1'b1;
            id_d[alloc_idx]    = addr_id_i;
            cnt_d[alloc_idx]   = delay_sat;
            older_d[alloc_idx] = '0;
            for (int unsigned j = 0; j < NumSlots; j++) begin
                older_d[j][alloc_idx] = valid_q[j];
            end
        end
    end

    always_comb begin
        rel_valid_d = rel_valid_q;
        rel_id_d    = rel_id_q;
        rel_slot_d  = rel_slot_q;
        if (rel_load) begin
            rel_valid_d = pick_found;
        end
        if (release_en) begin
            rel_id_d   = id_q[pick_idx];
            rel_slot_d = pick_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            rel_valid_q <= 1'b0;
            rel_id_q    <= '0;
            rel_slot_q  <= '0;
            for (int unsigned i = 0; i < NumSlots; i++) begin
                id_q[i]    <= '0;
                cnt_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            older_q     <= older_d;
            rel_valid_q <= rel_valid_d;
            rel_id_q    <= rel_id_d;
            rel_slot_q  <= rel_slot_d;
        end
    end

    assign rel_valid_o = rel_valid_q;
    assign rel_id_o    = rel_id_q;
    assign rel_slot_o  = rel_slot_q;

`ifdef SIMMEM_DELAY_TRACKER_OCCUPANCY_EN
    localparam logic [SlotW:0] OccMax = (SlotW+1)'(NumSlots);

    logic [SlotW:0] occ_q, occ_d;

    always_comb begin
        occ_d = occ_q;
        if (alloc_en && !release_en) begin
            occ_d = occ_q + (SlotW+1)'(1);
        end else if (release_en && !alloc_en) begin
            occ_d = occ_q - (SlotW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy_o = occ_q;

    occupancy_bound_a: assert property (@(posedge clk_i) disable iff (rst_i) occ_q <= OccMax);
`endif

endmodule
